// File: rtl/intc_pkg.sv
// Shared types, default configuration and helpers for the interrupt controller.
package intc_pkg;

  // Default configuration; the top module re-exposes these as parameters.
  localparam int          DEF_NUM_IRQ    = 8;
  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;
  localparam logic [31:0] DEF_NMI_VECTOR = 32'h0000_0080;

  // Widest IRQ vector the priority encoder accepts.
  localparam int MAX_IRQ = 32;

  // Request handshake state machine.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } intc_state_e;

  // Lowest set index wins (index 0 is the highest priority); returns 0 when empty.
  function automatic int prio_lowest(input logic [MAX_IRQ-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/intc_edge_detect.sv
// Rising-edge detector producing a one-cycle pulse per input bit.
// Optional feature: define INTC_SYNC_EN to insert a two-flop synchroniser
// ahead of the edge detector (adds two cycles of capture latency).
module intc_edge_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] sampled;
  logic [WIDTH-1:0] prev_q;

`ifdef INTC_SYNC_EN
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // Two-flop synchroniser for asynchronous peripheral lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values
      // at the same edge, which is what gives a real two-stage pipeline.
      sync1_q <= in_i;
      sync2_q <= sync1_q;
    end
  end

  assign sampled = sync2_q;
`else
  assign sampled = in_i;
`endif

  // Remember the previous sample so a level-high line does not retrigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= sampled;
  end

  assign rise_o = sampled & ~prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt requester: edge-captures IRQ/NMI lines, masks and prioritises
// IRQs, and runs the request/acknowledge/EOI handshake with the CPU.
// Optional feature: INTC_SYNC_EN adds input synchronisers (see intc_edge_detect).
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int          NUM_IRQ    = DEF_NUM_IRQ,
  parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE,
  parameter logic [31:0] NMI_VECTOR = DEF_NMI_VECTOR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IRQ-1:0]         irq_in,
  input  logic                       nmi_in,
  input  logic                       mask_we,
  input  logic [NUM_IRQ-1:0]         mask_wdata,
  input  logic                       int_ack,
  input  logic                       nmi_ack,
  input  logic                       eoi,
  output logic                       int_req,
  output logic                       nmi_req,
  output logic [$clog2(NUM_IRQ)-1:0] int_id,
  output logic [31:0]                int_vector,
  output logic [31:0]                nmi_vector,
  output logic [NUM_IRQ-1:0]         pending,
  output logic                       busy
);

  localparam int ID_W = $clog2(NUM_IRQ);

  logic [NUM_IRQ-1:0] irq_rise;
  logic               nmi_rise;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [NUM_IRQ-1:0] elig;
  logic [MAX_IRQ-1:0] elig_ext;
  logic [ID_W-1:0]    lowest_id;
  logic               nmi_req_q, nmi_req_d;

  intc_state_e        state_q, state_d;
  logic [ID_W-1:0]    int_id_q, int_id_d;
  logic               int_req_q, int_req_d;
  logic               busy_q, busy_d;

  intc_edge_detect #(.WIDTH(NUM_IRQ)) u_irq_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_i   (irq_in),
    .rise_o (irq_rise)
  );

  intc_edge_detect #(.WIDTH(1)) u_nmi_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_i   (nmi_in),
    .rise_o (nmi_rise)
  );

  // Unmasked pending IRQs, widened for the shared priority encoder.
  assign elig = pending_q & ~mask_q;

  // Zero-extend the eligible set to the encoder width.
  always_comb begin
    elig_ext              = '0;
    elig_ext[NUM_IRQ-1:0] = elig;
  end

  assign lowest_id = ID_W'(prio_lowest(elig_ext));

  // Handshake next-state: pick an IRQ, hold the request, then wait for EOI.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    int_id_d  = int_id_q;
    int_req_d = int_req_q;
    clr_vec   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          int_id_d  = lowest_id;
          int_req_d = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          clr_vec[int_id_q] = 1'b1;
          int_req_d         = 1'b0;
          state_d           = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eoi) state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        int_req_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // A new edge on the same cycle as the acknowledge clear wins.
  assign pending_d = (pending_q & ~clr_vec) | irq_rise;
  assign nmi_req_d = (nmi_req_q & ~nmi_ack) | nmi_rise;

  // Handshake state and its registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      int_id_q  <= '0;
      int_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      int_id_q  <= int_id_d;
      int_req_q <= int_req_d;
      busy_q    <= busy_d;
    end
  end

  // Pending bits, mask register and NMI request; all IRQs masked out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      mask_q    <= '1;
      nmi_req_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      nmi_req_q <= nmi_req_d;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  assign int_req    = int_req_q;
  assign nmi_req    = nmi_req_q;
  assign int_id     = int_id_q;
  assign int_vector = VEC_BASE + 32'(int_id_q) * VEC_STRIDE;
  assign nmi_vector = NMI_VECTOR;
  assign pending    = pending_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios with
// literal expectations plus a per-cycle comparison against a behavioural model.
module tb_interrupt_controller;

  localparam int N = 8;
`ifdef INTC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic         nmi_in = 1'b0;
  logic         mask_we = 1'b0;
  logic [N-1:0] mask_wdata = '0;
  logic         int_ack = 1'b0;
  logic         nmi_ack = 1'b0;
  logic         eoi = 1'b0;
  logic         int_req, nmi_req, busy;
  logic [2:0]   int_id;
  logic [31:0]  int_vector, nmi_vector;
  logic [N-1:0] pending;

  int n_vec  = 0;
  int n_miss = 0;

  interrupt_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .nmi_in     (nmi_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_ack    (int_ack),
    .nmi_ack    (nmi_ack),
    .eoi        (eoi),
    .int_req    (int_req),
    .nmi_req    (nmi_req),
    .int_id     (int_id),
    .int_vector (int_vector),
    .nmi_vector (nmi_vector),
    .pending    (pending),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [N-1:0] m_prev = '0, m_pending = '0, m_mask = '1;
  bit [N-1:0] m_d1 = '0, m_d2 = '0;
  bit         m_nprev = 1'b0, m_nmi = 1'b0, m_nd1 = 1'b0, m_nd2 = 1'b0;
  bit         m_reqing = 1'b0, m_serving = 1'b0;
  int         m_id = 0;

  always @(negedge rst_n) begin
    m_prev = '0; m_pending = '0; m_mask = '1; m_d1 = '0; m_d2 = '0;
    m_nprev = 0; m_nmi = 0; m_nd1 = 0; m_nd2 = 0;
    m_reqing = 0; m_serving = 0; m_id = 0;
  end

  always @(posedge clk) begin
    bit [N-1:0] s_irq, i_rise, clr, elig;
    bit         s_nmi, n_rise, found;
    if (rst_n) begin
`ifdef INTC_SYNC_EN
      s_irq = m_d2; m_d2 = m_d1; m_d1 = irq_in;
      s_nmi = m_nd2; m_nd2 = m_nd1; m_nd1 = nmi_in;
`else
      s_irq = irq_in;
      s_nmi = nmi_in;
`endif
      i_rise = s_irq & ~m_prev; m_prev = s_irq;
      n_rise = s_nmi & ~m_nprev; m_nprev = s_nmi;
      clr  = '0;
      elig = m_pending & ~m_mask;
      if (m_reqing) begin
        if (int_ack) begin
          clr[m_id] = 1'b1;
          m_reqing  = 0;
          m_serving = 1;
        end
      end else if (m_serving) begin
        if (eoi) m_serving = 0;
      end else if (elig != '0) begin
        found = 0;
        for (int i = 0; i < N; i++) begin
          if (elig[i] && !found) begin
            m_id  = i;
            found = 1;
          end
        end
        m_reqing = 1;
      end
      m_pending = (m_pending & ~clr) | i_rise;
      if (mask_we) m_mask = mask_wdata;
      m_nmi = (m_nmi & ~nmi_ack) | n_rise;
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc int_req", {31'b0, int_req}, {31'b0, m_reqing});
      check("cyc nmi_req", {31'b0, nmi_req}, {31'b0, m_nmi});
      check("cyc int_id", {29'b0, int_id}, 32'(m_id));
      check("cyc int_vector", int_vector, 32'h100 + 32'(m_id) * 32'h10);
      check("cyc nmi_vector", nmi_vector, 32'h80);
      check("cyc pending", {24'b0, pending}, {24'b0, m_pending});
      check("cyc busy", {31'b0, busy}, {31'b0, m_reqing | m_serving});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_mask(input logic [N-1:0] v);
    mask_we = 1'b1; mask_wdata = v;
    step();
    mask_we = 1'b0;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; step(); int_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; step(); eoi = 1'b0;
  endtask

  // Asynchronous reset assertion mid-cycle; outputs must clear before the next edge.
  task automatic apply_reset(input string tag);
    #3 rst_n = 1'b0;
    #1;
    check({tag, " rst int_req"}, {31'b0, int_req}, 32'h0);
    check({tag, " rst nmi_req"}, {31'b0, nmi_req}, 32'h0);
    check({tag, " rst int_id"}, {29'b0, int_id}, 32'h0);
    check({tag, " rst int_vector"}, int_vector, 32'h100);
    check({tag, " rst pending"}, {24'b0, pending}, 32'h0);
    check({tag, " rst busy"}, {31'b0, busy}, 32'h0);
    #2 rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #2;
    check("init int_req", {31'b0, int_req}, 32'h0);
    check("init pending", {24'b0, pending}, 32'h0);
    check("init busy", {31'b0, busy}, 32'h0);
    check("init int_id", {29'b0, int_id}, 32'h0);
    rst_n = 1'b1;
    step();

    // 1: single IRQ 5, measured capture latency, request and acknowledge
    write_mask(8'h00);
    irq_in = 8'h20;
    step();
    irq_in = '0;
    lat = 1;
    while (pending == '0 && lat < 10) begin
      step();
      lat++;
    end
    check("s1 capture latency", 32'(lat), 32'(1 + LAT));
    check("s1 pending", {24'b0, pending}, 32'h20);
    check("s1 no req yet", {31'b0, int_req}, 32'h0);
    step();
    check("s1 int_req", {31'b0, int_req}, 32'h1);
    check("s1 int_id", {29'b0, int_id}, 32'h5);
    check("s1 int_vector", int_vector, 32'h150);
    pulse_ack();
    check("s1 ack int_req", {31'b0, int_req}, 32'h0);
    check("s1 ack pending", {24'b0, pending}, 32'h0);
    check("s1 ack busy", {31'b0, busy}, 32'h1);

    // 2: higher-priority edge during service waits for EOI, then one IDLE cycle
    irq_in = 8'h04;
    step();
    irq_in = '0;
    repeat (LAT) step();
    check("s2 pending", {24'b0, pending}, 32'h04);
    check("s2 no nesting", {29'b0, int_id}, 32'h5);
    pulse_eoi();
    check("s2 idle int_req", {31'b0, int_req}, 32'h0);
    check("s2 idle busy", {31'b0, busy}, 32'h0);
    step();
    check("s2 int_req", {31'b0, int_req}, 32'h1);
    check("s2 int_id", {29'b0, int_id}, 32'h2);
    check("s2 int_vector", int_vector, 32'h120);
    pulse_ack();
    pulse_eoi();

    // 3: masked out of reset; unmask releases the request; level-high no retrigger
    apply_reset("s3");
    irq_in = 8'h01;
    repeat (LAT + 3) step();
    check("s3 masked pending", {24'b0, pending}, 32'h01);
    check("s3 masked no req", {31'b0, int_req}, 32'h0);
    write_mask(8'hFE);
    step();
    check("s3 int_req", {31'b0, int_req}, 32'h1);
    check("s3 int_id", {29'b0, int_id}, 32'h0);
    check("s3 int_vector", int_vector, 32'h100);
    pulse_ack();
    step();
    check("s3 level no retrigger", {24'b0, pending}, 32'h0);
    irq_in = '0;
    pulse_eoi();

    // 4: simultaneous edges resolve by priority; masking never withdraws a request
    write_mask(8'h00);
    irq_in = 8'h0A;
    step();
    irq_in = '0;
    repeat (LAT) step();
    step();
    check("s4 first id", {29'b0, int_id}, 32'h1);
    write_mask(8'hFF);
    check("s4 req held under mask", {31'b0, int_req}, 32'h1);
    pulse_ack();
    check("s4 pending after ack", {24'b0, pending}, 32'h08);
    write_mask(8'h00);
    pulse_eoi();
    step();
    check("s4 second id", {29'b0, int_id}, 32'h3);
    check("s4 second vector", int_vector, 32'h130);

    // 5: NMI alongside a maskable request; both acknowledged together
    nmi_in = 1'b1;
    step();
    nmi_in = 1'b0;
    repeat (LAT) step();
    check("s5 nmi_req", {31'b0, nmi_req}, 32'h1);
    check("s5 nmi_vector", nmi_vector, 32'h80);
    check("s5 int_req held", {31'b0, int_req}, 32'h1);
    int_ack = 1'b1; nmi_ack = 1'b1;
    step();
    int_ack = 1'b0; nmi_ack = 1'b0;
    check("s5 both int_req", {31'b0, int_req}, 32'h0);
    check("s5 both nmi_req", {31'b0, nmi_req}, 32'h0);
    // New NMI edge landing on the same edge as an acknowledge wins.
    nmi_in = 1'b1;
    repeat (LAT) step();
    nmi_ack = 1'b1;
    step();
    nmi_ack = 1'b0;
    check("s5 edge beats ack", {31'b0, nmi_req}, 32'h1);
    nmi_ack = 1'b1;
    step();
    nmi_ack = 1'b0;
    nmi_in = 1'b0;
    check("s5 nmi cleared", {31'b0, nmi_req}, 32'h0);

    // 6: reset mid-service with pending IRQ and NMI outstanding
    irq_in = 8'h40; nmi_in = 1'b1;
    step();
    irq_in = '0; nmi_in = 1'b0;
    repeat (LAT) step();
    check("s6 pre pending", {24'b0, pending}, 32'h40);
    check("s6 pre busy", {31'b0, busy}, 32'h1);
    apply_reset("s6");
    repeat (3) step();
    check("s6 post busy", {31'b0, busy}, 32'h0);
    check("s6 post int_req", {31'b0, int_req}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
